// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  localparam int PORT_W  = 2;
  localparam int BURST_W = 4;
  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // One-hot acknowledge vector for a port index.
  function automatic logic [N_PORTS-1:0] port_onehot(input logic [PORT_W-1:0] idx);
    port_onehot      = '0;
    port_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first requesting port after 'last'.
module sdram_rr_pick
  import sdram_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  last,
  output logic [PORT_W-1:0]  idx,
  output logic               any
);

  // Scan last+4 (== last) down to last+1 so the closest successor wins.
  always_comb begin
    idx = last;
    for (int k = N_PORTS; k >= 1; k--) begin
      if (req[last + PORT_W'(k)]) idx = last + PORT_W'(k);
    end
  end

  assign any = |req;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared SDRAM controller port.
// Grants one of four requesters, steers the mux select, issues a single
// RD/WR strobe held until the controller reports done, and acknowledges it.
// Optional WAIT watchdog: define SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,   // fixed at 4 to match the 2-bit select
  parameter int MAX_BURST = 4,   // transactions per grant, 1..15
  parameter int TIMEOUT   = 255  // watchdog limit in WAIT cycles
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic [NUM_PORTS-1:0] iREQ,
  input  logic [NUM_PORTS-1:0] iWE,
  output logic [NUM_PORTS-1:0] oACK,
  output logic [PORT_W-1:0]    oSelect,
  output logic                 oGrant_Valid,
  output logic                 oSDR_RD,
  output logic                 oSDR_WR,
  input  logic                 iSDR_Done,
  output logic                 oERR
);

  localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);
  localparam logic [7:0]         TIMEOUT_LIM = 8'(TIMEOUT);

  state_e               state_q, state_d;
  logic [PORT_W-1:0]    sel_q, sel_d;
  logic [PORT_W-1:0]    last_q, last_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 gv_q, gv_d;
  logic                 rd_q, rd_d;
  logic                 wr_q, wr_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;

  logic [PORT_W-1:0] pick_idx;
  logic              pick_any;
  logic              wait_done;
  logic              burst_room;
  logic              force_rearb;
  logic              gap_continue;

  sdram_rr_pick u_pick (
    .req  (iREQ),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign wait_done    = (state_q == ST_WAIT) && iSDR_Done;
  assign burst_room   = burst_q < MAX_BURST_C;
  assign gap_continue = iREQ[sel_q] && burst_room && !force_rearb;

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
  logic       wait_abort;

  assign wait_abort  = (state_q == ST_WAIT) && !iSDR_Done && (wd_q == TIMEOUT_LIM - 8'd1);
  // An aborted transaction (oERR high during GAP) always hands the port on.
  assign force_rearb = err_q;
  assign oERR        = err_q;

  // Watchdog counts WAIT cycles; cleared in every other state.
  always_comb begin
    wd_d  = (state_q == ST_WAIT) ? wd_q + 8'd1 : 8'd0;
    err_d = wait_abort;
  end

  // Watchdog registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LIM;
  assign force_rearb    = 1'b0;
  assign oERR           = 1'b0;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_any) state_d = ST_CMD;
      ST_CMD:  state_d = ST_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
      ST_WAIT: if (wait_done || wait_abort) state_d = ST_GAP;
`else
      ST_WAIT: if (wait_done) state_d = ST_GAP;
`endif
      ST_GAP:  state_d = gap_continue ? ST_CMD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: select, strobes, acknowledge, burst count.
  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    sel_d   = sel_q;
    last_d  = last_q;
    burst_d = burst_q;
    gv_d    = gv_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ack_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d = pick_idx;
          gv_d  = 1'b1;
        end
      end
      ST_CMD: begin
        wr_d = iWE[sel_q];
        rd_d = ~iWE[sel_q];
      end
      ST_WAIT: begin
        if (wait_done) begin
          rd_d  = 1'b0;
          wr_d  = 1'b0;
          ack_d = port_onehot(sel_q);
          if (burst_room) burst_d = burst_q + 1'b1;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (wait_abort) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end
`endif
      end
      ST_GAP: begin
        if (!gap_continue) begin
          last_d  = sel_q;
          burst_d = '0;
          gv_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers; last=3 out of reset so port 0 wins first.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sel_q   <= '0;
      last_q  <= 2'd3;
      burst_q <= '0;
      gv_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      gv_q    <= gv_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
    end
  end

  assign oSelect      = sel_q;
  assign oGrant_Valid = gv_q;
  assign oSDR_RD      = rd_q;
  assign oSDR_WR      = wr_q;
  assign oACK         = ack_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: directed cases plus randomized
// requesters against a transaction-level reference of the grant rules.
// Watchdog case runs when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_port_arbiter;

  localparam int MAX_B = 4;
  localparam int TMO   = 10;

  logic       iCLK, iRST;
  logic [3:0] iREQ, iWE, oACK;
  logic [1:0] oSelect;
  logic       oGrant_Valid, oSDR_RD, oSDR_WR, iSDR_Done, oERR;

  int n_tests = 0;
  int n_fail  = 0;
  int m_last;      // reference: last granted port
  int m_sel;       // reference: select held by the mux
  int demand[4];   // outstanding transactions each requester still wants

  sdram_port_arbiter #(.NUM_PORTS(4), .MAX_BURST(MAX_B), .TIMEOUT(TMO)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iREQ         (iREQ),
    .iWE          (iWE),
    .oACK         (oACK),
    .oSelect      (oSelect),
    .oGrant_Valid (oGrant_Valid),
    .oSDR_RD      (oSDR_RD),
    .oSDR_WR      (oSDR_WR),
    .iSDR_Done    (iSDR_Done),
    .oERR         (oERR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic gv, input int sel,
                            input logic rd, input logic wr, input logic [3:0] ack,
                            input logic err);
    check({tag, ".gv"},  32'(oGrant_Valid), 32'(gv));
    check({tag, ".sel"}, 32'(oSelect), 32'(sel));
    check({tag, ".rd"},  32'(oSDR_RD), 32'(rd));
    check({tag, ".wr"},  32'(oSDR_WR), 32'(wr));
    check({tag, ".ack"}, 32'(oACK), 32'(ack));
    check({tag, ".err"}, 32'(oERR), 32'(err));
    check({tag, ".excl"}, 32'(oSDR_RD & oSDR_WR), 32'd0);
  endtask

  // Sample #1 after the active edge; inputs are then changed for the next edge.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // Reference round-robin: first requester after 'last', modulo 4.
  function automatic int rr_pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_req(input int p, input logic we, input int n);
    iWE[p]    = we;
    demand[p] = n;
    iREQ[p]   = 1'b1;
  endtask

  // Idle requesters (except those masked) randomly start a new request.
  task automatic raise_some(input logic [3:0] excl);
    for (int i = 0; i < 4; i++) begin
      if (!iREQ[i] && !excl[i] && $urandom_range(3) == 0) begin
        iWE[i]    = 1'($urandom_range(1));
        demand[i] = int'($urandom_range(6, 1));
        iREQ[i]   = 1'b1;
      end
    end
  endtask

  // One arbitration opportunity: either an idle cycle, or a complete grant
  // with its burst of transactions. lat=0 picks a random done latency.
  task automatic do_grant(input int lat, input bit rnd);
    int p;
    int burst;
    int l;
    logic [3:0] own;
    if (rnd) raise_some(4'b0000);
    iSDR_Done = 1'($urandom_range(1));   // ignored outside WAIT
    p = rr_pick(m_last, iREQ);
    tick();
    if (p < 0) begin
      check_outs("idle", 1'b0, m_sel, 1'b0, 1'b0, 4'b0, 1'b0);
      return;
    end
    m_sel = p;
    check_outs("grant", 1'b1, p, 1'b0, 1'b0, 4'b0, 1'b0);
    own   = 4'(1 << p);
    burst = 0;
    forever begin
      if (rnd) raise_some(own);
      iSDR_Done = 1'($urandom_range(1));
      tick();
      check_outs("strobe", 1'b1, p, !iWE[p], iWE[p], 4'b0, 1'b0);
      l = (lat > 0) ? lat : int'($urandom_range(4, 1));
      for (int j = 1; j < l; j++) begin
        iSDR_Done = 1'b0;
        if (rnd) raise_some(own);
        tick();
        check_outs("wait", 1'b1, p, !iWE[p], iWE[p], 4'b0, 1'b0);
      end
      iSDR_Done = 1'b1;
      if (rnd) raise_some(own);
      tick();
      check_outs("done", 1'b1, p, 1'b0, 1'b0, own, 1'b0);
      burst++;
      demand[p]--;
      if (demand[p] <= 0) iREQ[p] = 1'b0;
      iSDR_Done = 1'($urandom_range(1));
      if (rnd) raise_some(own);
      tick();
      if (iREQ[p] && burst < MAX_B) begin
        check_outs("gap_cont", 1'b1, p, 1'b0, 1'b0, 4'b0, 1'b0);
      end else begin
        check_outs("gap_end", 1'b0, p, 1'b0, 1'b0, 4'b0, 1'b0);
        m_last = p;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    iRST = 1'b1; iREQ = '0; iWE = '0; iSDR_Done = 1'b0;
    for (int i = 0; i < 4; i++) demand[i] = 0;
    m_last = 3;
    m_sel  = 0;
    #3;
    check_outs("reset", 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    tick();
    tick();
    iRST = 1'b0;

    // All four request, one transaction each: rotation 0,1,2,3.
    for (int i = 0; i < 4; i++) set_req(i, 1'($urandom_range(1)), 1);
    for (int i = 0; i < 4; i++) do_grant(1, 1'b0);

    // Single read from port 0, done after 3 WAIT cycles.
    set_req(0, 1'b0, 1);
    do_grant(3, 1'b0);

    // Write-only port 1.
    set_req(1, 1'b1, 1);
    do_grant(2, 1'b0);

    // Port 2 wants 6 with port 1 waiting: 4, then port 1, then port 2 again.
    set_req(2, 1'b0, 6);
    set_req(1, 1'b0, 1);
    for (int i = 0; i < 3; i++) do_grant(0, 1'b0);
    do_grant(0, 1'b0);   // nothing left: idle cycle

    // Randomized requesters.
    for (int n = 0; n < 300; n++) do_grant(0, 1'b1);

    // Reset in WAIT: strobe drops at once, no acknowledge.
    iREQ = '0;
    for (int i = 0; i < 4; i++) demand[i] = 0;
    set_req(3, 1'b0, 1);
    iSDR_Done = 1'b0;
    tick();
    tick();
    check("pre_rst_strobe", 32'(oSDR_RD | oSDR_WR), 32'd1);
    iRST = 1'b1;
    #1;
    check_outs("mid_rst", 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    #1;
    iRST = 1'b0;
    iREQ = '0;
    demand[3] = 0;
    m_last = 3;
    m_sel  = 0;
    for (int i = 0; i < 4; i++) set_req(i, 1'($urandom_range(1)), 1);
    do_grant(2, 1'b0);   // port 0 first after reset
    while (iREQ != 4'b0) do_grant(0, 1'b0);

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Watchdog: port 0 never completes; oERR, no ack, port 1 served next.
    set_req(0, 1'b0, 1);
    set_req(1, 1'b1, 1);
    iSDR_Done = 1'b0;
    tick();
    check_outs("tmo_grant", 1'b1, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    for (int k = 1; k <= TMO + 1; k++) begin
      tick();
      if (k <= TMO) check_outs("tmo_wait", 1'b1, 0, 1'b1, 1'b0, 4'b0, 1'b0);
      else          check_outs("tmo_err", 1'b1, 0, 1'b0, 1'b0, 4'b0, 1'b1);
    end
    tick();
    check_outs("tmo_gap", 1'b0, 0, 1'b0, 1'b0, 4'b0, 1'b0);
    m_last = 0;
    m_sel  = 0;
    do_grant(1, 1'b0);   // port 1
    do_grant(1, 1'b0);   // port 0 retries
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Dynamic arbiter and sequencer for the shared SDRAM controller port. Replaces the static 2-bit port-select input of the four-way SDRAM multiplexer.
- Serves four requesters: port 0 = host, ports 1-3 = async clients.
- Grants by round-robin, drives the mux select, and issues single RD/WR strobes held until the controller's done.
- Returns a one-cycle acknowledge per completed transaction. Address and data stay in the existing multiplexer, steered by oSelect.

Parameters:
- NUM_PORTS, 4, number of requesters; fixed at 4, matching the 2-bit select.
- MAX_BURST, 4, max back-to-back transactions per grant before re-arbitration (1..15).
- TIMEOUT, 255, WAIT-state watchdog limit in cycles; used only with the optional feature.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST  in  1  asynchronous active-high reset.
- iREQ  in  4  per-port request level; held until the matching oACK.
- iWE   in  4  per-port direction: 1=write, 0=read; stable while iREQ is high.
- oACK  out 4  one-cycle pulse on the granted port when its transaction completes.
- oSelect  out 2  registered port index to the SDRAM multiplexer.
- oGrant_Valid  out 1  high while a port owns the SDRAM (CMD/WAIT/GAP).
- oSDR_RD  out 1  read strobe to the SDRAM controller.
- oSDR_WR  out 1  write strobe to the SDRAM controller.
- iSDR_Done  in  1  controller completion, level.
- oERR  out 1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, iRST=1): all outputs 0 (oSelect=0); state IDLE; burst count 0; last-grant pointer = 3, so port 0 wins first.
- States: IDLE, CMD, WAIT, GAP.
- IDLE, iREQ=0: stay; outputs 0.
- IDLE, iREQ!=0: choose the first requesting port scanning last+1, last+2, ... mod 4. Register oSelect, set oGrant_Valid=1, go CMD.
- CMD: register oSDR_WR=iWE[sel] and oSDR_RD=~iWE[sel]; go WAIT. A strobe is therefore visible 2 cycles after the request is sampled.
- WAIT: hold the strobe until iSDR_Done=1. iSDR_Done is ignored in every other state.
  - On iSDR_Done=1: deassert strobes, pulse oACK[sel], increment burst count, go GAP.
- GAP: exactly one idle cycle; oACK is 0 again here.
  - If iREQ[sel]=1 and burst count<MAX_BURST: go CMD with the same oSelect.
  - Else: last=sel, burst count=0, oGrant_Valid=0, go IDLE.
- Invariant: oSDR_RD and oSDR_WR are never high together. oSelect changes only in IDLE.
- Request dropped during CMD/WAIT: the transaction still completes and oACK still pulses (requester protocol violation; tolerated).
- Simultaneous requests: strict rotation; no port waits more than 3 grants.
- Burst counter width is 4 bits; saturates at MAX_BURST.
- Reset mid-transaction: strobes drop immediately (async); no oACK.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined: an 8-bit counter runs in WAIT. If it reaches TIMEOUT with no iSDR_Done:
  - drop strobes, pulse oERR, pulse no oACK;
  - go GAP and force re-arbitration (last=sel).
- Not defined: WAIT is unbounded and oERR is tied 0.

Decomposition:
- Package sdram_arb_pkg: state encoding (IDLE=0, CMD=1, WAIT=2, GAP=3), PORT_W=2, BURST_W=4.
- Sub-module sdram_rr_pick: combinational round-robin picker, inputs (req[3:0], last[1:0]), outputs (idx[1:0], any).
- Top contains the FSM, counters and output registers.

Test Plan:
- Reset, then iREQ=0001, iWE=0, iSDR_Done after 3 WAIT cycles -> oSelect=0, oSDR_RD high 3 cycles, oACK=0001 one cycle, then IDLE.
- iREQ=1111 held, each done after 1 cycle, MAX_BURST=1 -> grants in order 0,1,2,3,0; oSelect never changes outside IDLE.
- iREQ=0100 held for 6 transactions, MAX_BURST=4, port 1 requests from the start -> port 2 gets 4 acks, then port 1 granted, then port 2 resumes.
- iWE=0010 with iREQ=0010 -> oSDR_WR only; oSDR_RD stays 0 across every cycle.
- iRST pulsed during WAIT -> oSDR_RD/WR go 0 that cycle with no oACK; after release, port 0 is granted first.
- SDRAM_ARB_TIMEOUT_EN, TIMEOUT=10, iSDR_Done never asserted -> oERR pulses 10 cycles into WAIT, no oACK, next requester granted.
